// File: rtl/defunnel_egress_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : defunnel_egress_buf_if
// Brief    : Upstream word/config handshake and downstream tagged-word bus
//            of the defunnel egress buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface defunnel_egress_buf_if #(
    parameter int CHUNKS  = 6,
    parameter int CHUNK_W = 128
);
    localparam int W = CHUNKS * CHUNK_W;

    // Upstream word and frame-length configuration
    logic          t_req;
    logic          t_ack;
    logic [W-1:0]  t_data;
    logic          t_cfg_req;
    logic          t_cfg_ack;
    logic [15:0]   t_cfg_data;

    // Downstream tagged word
    logic          i_req;
    logic          i_ack;
    logic [W-1:0]  i_data;
    logic          i_first;
    logic          i_last;
    logic [7:0]    i_seq;
    logic [1:0]    occupancy;

    // The buffer itself
    modport slave (
        input  t_req, t_data, t_cfg_req, t_cfg_data, i_ack,
        output t_ack, t_cfg_ack, i_req, i_data, i_first, i_last, i_seq, occupancy
    );

    // Upstream producer plus downstream consumer
    modport master (
        output t_req, t_data, t_cfg_req, t_cfg_data, i_ack,
        input  t_ack, t_cfg_ack, i_req, i_data, i_first, i_last, i_seq, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/defunnel_egress_buf.sv
`default_nettype none
// ============================================================================
// Module   : defunnel_egress_buf
// Brief    : Two-entry elastic buffer tagging defunnel wide words with
//            frame first/last/sequence; breaks the consumer ack path.
// Revision : 1.0 - initial release
// ============================================================================
module defunnel_egress_buf #(
    parameter int CHUNKS  = 6,
    parameter int CHUNK_W = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    defunnel_egress_buf_if.slave  bus
);
    localparam int W = CHUNKS * CHUNK_W;

    // Slot storage
    logic [W-1:0]  r_slot_data [2];
    logic [1:0]    r_slot_first;
    logic [1:0]    r_slot_last;
    logic [7:0]    r_slot_seq  [2];

    // Queue control
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    // Frame tracking
    logic [15:0]   r_pos;
    logic [15:0]   r_frame_len;
    logic [7:0]    r_frame_seq;

    logic          w_t_ack;
    logic          w_i_req;
    logic          w_cfg_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_cfg;
    logic          w_tag_first;
    logic          w_tag_last;

    // Acceptance depends on registered state only, never on i_ack
    assign w_t_ack   = (r_count != 2'd2);
    assign w_i_req   = (r_count != 2'd0);
    assign w_cfg_ack = (r_pos == 16'd0);

    assign w_push = bus.t_req & w_t_ack;
    assign w_pop  = w_i_req & bus.i_ack;
    assign w_cfg  = bus.t_cfg_req & w_cfg_ack;

    // frame_len is never 0, so the subtraction cannot wrap
    assign w_tag_first = (r_pos == 16'd0);
    assign w_tag_last  = (r_pos == (r_frame_len - 16'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_data[0] <= '0;
            r_slot_data[1] <= '0;
            r_slot_first   <= '0;
            r_slot_last    <= '0;
            r_slot_seq[0]  <= '0;
            r_slot_seq[1]  <= '0;
        end else if (w_push) begin
            r_slot_data[r_wr_ptr]  <= bus.t_data;
            r_slot_first[r_wr_ptr] <= w_tag_first;
            r_slot_last[r_wr_ptr]  <= w_tag_last;
            r_slot_seq[r_wr_ptr]   <= r_frame_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos       <= 16'd0;
            r_frame_seq <= 8'd0;
        end else if (w_push) begin
            if (w_tag_last) begin
                r_pos       <= 16'd0;
                r_frame_seq <= r_frame_seq + 8'd1;
            end else begin
                r_pos       <= r_pos + 16'd1;
            end
        end
    end

    // A same-cycle push was already tagged with the old length above
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_len <= 16'd1;
        end else if (w_cfg) begin
            r_frame_len <= (bus.t_cfg_data == 16'd0) ? 16'd1 : bus.t_cfg_data;
        end
    end

    assign bus.t_ack     = w_t_ack;
    assign bus.t_cfg_ack = w_cfg_ack;
    assign bus.i_req     = w_i_req;
    assign bus.i_data    = r_slot_data[r_rd_ptr];
    assign bus.i_first   = r_slot_first[r_rd_ptr];
    assign bus.i_last    = r_slot_last[r_rd_ptr];
    assign bus.i_seq     = r_slot_seq[r_rd_ptr];
    assign bus.occupancy = r_count;

endmodule
`default_nettype wire

// File: tb/tb_defunnel_egress_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_defunnel_egress_buf
// Brief    : Self-checking bench for defunnel_egress_buf against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_defunnel_egress_buf;
    localparam int CHUNKS  = 4;
    localparam int CHUNK_W = 16;
    localparam int W       = CHUNKS * CHUNK_W;

    typedef struct packed {
        logic [W-1:0] d;
        logic         f;
        logic         l;
        logic [7:0]   s;
    } word_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: words queued in order, plus frame bookkeeping
    word_t mq[$];
    int    m_pos;
    int    m_len;
    int    m_seq;

    defunnel_egress_buf_if #(.CHUNKS(CHUNKS), .CHUNK_W(CHUNK_W)) bus ();

    defunnel_egress_buf #(.CHUNKS(CHUNKS), .CHUNK_W(CHUNK_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pos = 0;
        m_len = 1;
        m_seq = 0;
    endtask

    // Advance one clock; model transfers are decided from pre-edge state
    task automatic tick();
        bit    do_pop;
        bit    do_push;
        bit    do_cfg;
        int    cfg_val;
        word_t w;
        do_pop  = bus.i_ack && (mq.size() != 0);
        do_push = bus.t_req && (mq.size() != 2);
        do_cfg  = bus.t_cfg_req && (m_pos == 0);
        cfg_val = int'(bus.t_cfg_data);
        w.d = bus.t_data;
        w.f = (m_pos == 0);
        w.l = (m_pos == m_len - 1);
        w.s = 8'(m_seq % 256);
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(w);
            if (w.l) begin
                m_pos = 0;
                m_seq = (m_seq + 1) % 256;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        if (do_cfg) m_len = (cfg_val == 0) ? 1 : cfg_val;
    endtask

    task automatic idle_inputs();
        bus.t_req      = 1'b0;
        bus.t_data     = '0;
        bus.t_cfg_req  = 1'b0;
        bus.t_cfg_data = 16'd0;
        bus.i_ack      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.i_req !== 1'b0) begin errors++; $display("FAIL reset_i_req got %b want 0", bus.i_req); end
        checks++; if (bus.t_ack !== 1'b1) begin errors++; $display("FAIL reset_t_ack got %b want 1", bus.t_ack); end
        checks++; if (bus.t_cfg_ack !== 1'b1) begin errors++; $display("FAIL reset_t_cfg_ack got %b want 1", bus.t_cfg_ack); end
        checks++; if (bus.i_data !== '0) begin errors++; $display("FAIL reset_i_data got %h want 0", bus.i_data); end
        checks++; if ({bus.i_first, bus.i_last} !== 2'b00) begin errors++; $display("FAIL reset_tags got %b want 00", {bus.i_first, bus.i_last}); end
        checks++; if (bus.i_seq !== 8'd0) begin errors++; $display("FAIL reset_i_seq got %0d want 0", bus.i_seq); end
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_fill_hold();
        logic [W-1:0] a;
        logic [W-1:0] b;
        do_reset();
        a = rand_word();
        b = rand_word();
        bus.t_req  = 1'b1;
        bus.t_data = a;
        checks++; if (bus.i_req !== 1'b0) begin errors++; $display("FAIL fill_no_bypass got %b want 0", bus.i_req); end
        tick();
        checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL fill_occ1 got %0d want 1", bus.occupancy); end
        checks++; if (bus.i_req !== 1'b1 || bus.i_data !== a) begin errors++; $display("FAIL fill_first_word got %b/%h want 1/%h", bus.i_req, bus.i_data, a); end
        bus.t_data = b;
        tick();
        bus.t_req = 1'b0;
        checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL fill_occ2 got %0d want 2", bus.occupancy); end
        checks++; if (bus.t_ack !== 1'b0) begin errors++; $display("FAIL fill_full_t_ack got %b want 0", bus.t_ack); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.i_data !== a || bus.i_seq !== 8'd0) begin errors++; $display("FAIL fill_hold got %h/%0d want %h/0", bus.i_data, bus.i_seq, a); end
        end
        // Full: a push offered together with a pop must be refused
        bus.t_req  = 1'b1;
        bus.t_data = rand_word();
        bus.i_ack  = 1'b1;
        tick();
        bus.t_req = 1'b0;
        checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL full_no_push occ got %0d want 1", bus.occupancy); end
        checks++; if (bus.i_data !== b || bus.i_seq !== 8'd1) begin errors++; $display("FAIL full_next_word got %h/%0d want %h/1", bus.i_data, bus.i_seq, b); end
        checks++; if (bus.t_ack !== 1'b1) begin errors++; $display("FAIL full_t_ack_return got %b want 1", bus.t_ack); end
        tick();
        checks++; if (bus.occupancy !== 2'd0 || bus.i_req !== 1'b0) begin errors++; $display("FAIL fill_drain got %0d/%b want 0/0", bus.occupancy, bus.i_req); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        do_reset();
        bus.i_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = rand_word();
            bus.t_req  = 1'b1;
            bus.t_data = w;
            tick();
            checks++;
            if (bus.i_req !== 1'b1 || bus.i_data !== w || bus.i_seq !== 8'(k) ||
                bus.i_first !== 1'b1 || bus.i_last !== 1'b1 || bus.occupancy !== 2'd1) begin
                errors++;
                $display("FAIL b2b_word%0d got req=%b data=%h seq=%0d f=%b l=%b occ=%0d want 1/%h/%0d/1/1/1",
                         k, bus.i_req, bus.i_data, bus.i_seq, bus.i_first, bus.i_last, bus.occupancy, w, k);
            end
        end
        bus.t_req = 1'b0;
        tick();
        checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL b2b_drain got %0d want 0", bus.occupancy); end
        idle_inputs();
    endtask

    task automatic test_frame3();
        bit   exp_f [7];
        bit   exp_l [7];
        int   exp_s [7];
        exp_f = '{1, 0, 0, 1, 0, 0, 1};
        exp_l = '{0, 0, 1, 0, 0, 1, 0};
        exp_s = '{0, 0, 0, 1, 1, 1, 2};
        do_reset();
        bus.t_cfg_req  = 1'b1;
        bus.t_cfg_data = 16'd3;
        tick();
        bus.t_cfg_req = 1'b0;
        bus.i_ack     = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.t_req  = 1'b1;
            bus.t_data = rand_word();
            tick();
            checks++;
            if (bus.i_first !== exp_f[k] || bus.i_last !== exp_l[k] || bus.i_seq !== 8'(exp_s[k])) begin
                errors++;
                $display("FAIL frame3_word%0d got f=%b l=%b seq=%0d want %b/%b/%0d",
                         k, bus.i_first, bus.i_last, bus.i_seq, exp_f[k], exp_l[k], exp_s[k]);
            end
        end
    endtask

    // Continues from test_frame3: one word of the third frame already pushed
    task automatic test_cfg_boundary();
        bus.t_cfg_req  = 1'b1;
        bus.t_cfg_data = 16'd5;
        bus.t_req      = 1'b0;
        checks++; if (bus.t_cfg_ack !== 1'b0) begin errors++; $display("FAIL cfg_wait_pos1 got %b want 0", bus.t_cfg_ack); end
        tick();
        bus.t_req  = 1'b1;
        bus.t_data = rand_word();
        tick();
        checks++; if (bus.t_cfg_ack !== 1'b0) begin errors++; $display("FAIL cfg_wait_pos2 got %b want 0", bus.t_cfg_ack); end
        bus.t_data = rand_word();
        tick();
        bus.t_req = 1'b0;
        checks++; if (bus.i_last !== 1'b1) begin errors++; $display("FAIL cfg_frame_end_last got %b want 1", bus.i_last); end
        checks++; if (bus.t_cfg_ack !== 1'b1) begin errors++; $display("FAIL cfg_ack_at_boundary got %b want 1", bus.t_cfg_ack); end
        tick();
        bus.t_cfg_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.t_req  = 1'b1;
            bus.t_data = rand_word();
            tick();
            checks++;
            if (bus.i_first !== (k == 0) || bus.i_last !== (k == 4) || bus.i_seq !== 8'd3) begin
                errors++;
                $display("FAIL cfg5_word%0d got f=%b l=%b seq=%0d want %b/%b/3",
                         k, bus.i_first, bus.i_last, bus.i_seq, (k == 0), (k == 4));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_len0_wrap();
        do_reset();
        bus.t_cfg_req  = 1'b1;
        bus.t_cfg_data = 16'd0;
        tick();
        bus.t_cfg_req = 1'b0;
        bus.i_ack     = 1'b1;
        for (int k = 0; k < 300; k++) begin
            bus.t_req  = 1'b1;
            bus.t_data = rand_word();
            tick();
            checks++;
            if (bus.i_first !== 1'b1 || bus.i_last !== 1'b1 || bus.i_seq !== 8'(k % 256)) begin
                errors++;
                $display("FAIL len0_word%0d got f=%b l=%b seq=%0d want 1/1/%0d",
                         k, bus.i_first, bus.i_last, bus.i_seq, k % 256);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] w;
        bus.i_ack  = 1'b0;
        bus.t_req  = 1'b1;
        bus.t_data = rand_word();
        tick();
        bus.t_data = rand_word();
        tick();
        bus.t_req = 1'b0;
        checks++; if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL midrst_pre_occ got %0d want 2", bus.occupancy); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.i_req !== 1'b0 || bus.occupancy !== 2'd0 || bus.t_ack !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async got req=%b occ=%0d t_ack=%b want 0/0/1", bus.i_req, bus.occupancy, bus.t_ack);
        end
        #1;
        reset = 1'b0;
        model_reset();
        w = rand_word();
        bus.t_req  = 1'b1;
        bus.t_data = w;
        tick();
        bus.t_req = 1'b0;
        checks++;
        if (bus.i_data !== w || bus.i_first !== 1'b1 || bus.i_seq !== 8'd0) begin
            errors++;
            $display("FAIL midrst_first_word got %h/f=%b/seq=%0d want %h/1/0", bus.i_data, bus.i_first, bus.i_seq, w);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        word_t got;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bus.t_req      = ($urandom_range(0, 3) != 0);
            bus.t_data     = rand_word();
            bus.i_ack      = ($urandom_range(0, 2) != 0);
            bus.t_cfg_req  = ($urandom_range(0, 7) == 0);
            bus.t_cfg_data = 16'($urandom_range(0, 4));
            checks++;
            if (bus.occupancy !== 2'(mq.size()) || bus.i_req !== (mq.size() != 0) ||
                bus.t_ack !== (mq.size() != 2) || bus.t_cfg_ack !== (m_pos == 0)) begin
                errors++;
                $display("FAIL rand_ctrl cyc%0d got occ=%0d req=%b t_ack=%b cfg_ack=%b want %0d/%b/%b/%b",
                         c, bus.occupancy, bus.i_req, bus.t_ack, bus.t_cfg_ack,
                         mq.size(), (mq.size() != 0), (mq.size() != 2), (m_pos == 0));
            end
            if (mq.size() != 0) begin
                got = {bus.i_data, bus.i_first, bus.i_last, bus.i_seq};
                checks++;
                if (got !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_word cyc%0d got %h want %h", c, got, mq[0]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        model_reset();
        idle_inputs();
        #12;
        test_reset();
        test_fill_hold();
        test_back_to_back();
        test_frame3();
        test_cfg_boundary();
        test_len0_wrap();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/defunnel_egress_buf.md
# defunnel_egress_buf

Two-entry elastic buffer directly downstream of the defunnel controller/datapath. It accepts each fully assembled wide word on a req/ack handshake, registers it, and presents it to the consumer with frame tags: first, last, and a frame sequence number. It breaks the combinational ack path from the consumer back into the defunnel stage while sustaining one word per cycle.

## Interface
Parameters:
- CHUNKS, 6, number of narrow chunks per wide word (2 × (targets − 1) of the upstream defunnel)
- CHUNK_W, 128, bits per chunk (8 complex samples × 16 bits)
- Derived: W = CHUNKS × CHUNK_W

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- t_req  in  1  upstream wide word valid (defunnel i_0_req)
- t_ack  out  1  buffer can accept this cycle
- t_data  in  W  assembled wide word
- t_cfg_req  in  1  frame-length config valid
- t_cfg_ack  out  1  config accepted this cycle
- t_cfg_data  in  16  frame length in words
- i_req  out  1  output word valid
- i_ack  in  1  consumer accepts
- i_data  out  W  output word
- i_first  out  1  word is first of its frame
- i_last  out  1  word is last of its frame
- i_seq  out  8  frame sequence number of the word
- occupancy  out  2  current entry count, 0..2

## Operation
- Transfer rules: push = t_req & t_ack; pop = i_req & i_ack; cfg = t_cfg_req & t_cfg_ack.
- Storage: two slots, each holding {data, first, last, seq}. Pointers wr_ptr and rd_ptr are 1 bit each; count is 2 bits, 0..2.
- t_ack = (count != 2). t_ack is derived from registered state only and never from i_ack.
- i_req = (count != 0). i_data and all tags come from slot[rd_ptr].
- Push: write slot[wr_ptr] and toggle wr_ptr. Pop: toggle rd_ptr. count += push − pop, so a simultaneous push and pop leaves count unchanged.
- Frame position counter pos (16 bits, counts 0..frame_len−1) advances on each push.
  - Tags captured at push: first = (pos == 0); last = (pos == frame_len − 1); seq = frame_seq.
  - If the pushed word is last: pos ← 0 and frame_seq ← frame_seq + 1 (wraps 255→0). Otherwise pos ← pos + 1.
- frame_len register (16 bits):
  - t_cfg_ack = (pos == 0), so config is taken only at a frame boundary.
  - On cfg, frame_len ← t_cfg_data; a value of 0 is coerced to 1.
  - If cfg and push occur in the same cycle, the pushed word is tagged with the old frame_len. The new value applies from the next push.
- frame_len = 1: every word has first = last = 1, and frame_seq increments on each word.

## Timing
- Reset values: count 0, pointers 0, pos 0, frame_len 1, frame_seq 0, slot contents 0. Outputs after reset: i_req 0, t_ack 1, t_cfg_ack 1, i_data 0, i_first 0, i_last 0, i_seq 0, occupancy 0.
- Latency: a word pushed at edge N is on i_data with i_req = 1 after edge N, one cycle later.
- Throughput: sustains 1 word/cycle with count steady at 1 when push and pop occur every cycle.
- Full (count = 2):
  - t_ack = 0, so no push is possible even if pop occurs that cycle.
  - t_ack returns to 1 in the cycle after the first pop.
- Empty (count = 0): i_req = 0. A pushed word is not bypassed combinationally to the output.
- Pointer wrap: the 1-bit pointers toggle naturally; the FIFO order of the two slots is preserved across any push/pop sequence.
- Reset asserted mid-operation: all words in flight are discarded, and outputs return to reset values asynchronously. The upstream stage must also be reset in the same event.
- i_data and tags are held stable while i_req = 1 and i_ack = 0.

## Test plan
- Reset, then push words A and B in consecutive cycles with i_ack = 0:
  - occupancy goes 1 → 2.
  - t_ack = 0 in the cycle after B is pushed.
  - i_data stays A and is stable.
- Assert i_ack continuously while pushing 10 back-to-back words (frame_len 1):
  - one output per cycle, in order, one-cycle latency, occupancy steady at 1.
  - i_seq runs 0..9; i_first = i_last = 1 on every word.
- Config frame_len = 3, then push 7 words:
  - first flags: 1,0,0,1,0,0,1
  - last flags: 0,0,1,0,0,1,0
  - i_seq: 0,0,0,1,1,1,2
- With pos = 1, assert t_cfg_req (data 5): t_cfg_ack stays 0 until the frame-last word is pushed. Config is then accepted, and the next frame has last on word 5.
- Config frame_len 0 → behaves as 1. Push 300 single-word frames: i_seq wraps 255 → 0.
- Assert reset with occupancy = 2 and i_ack = 0: in the same cycle i_req = 0, occupancy = 0, and t_ack = 1. After release, the first new word has i_first = 1 and i_seq = 0.
